// File: rtl/alu_4_arbiter_if.sv
// Requester/consumer bus for alu_4_arbiter: packed per-requester operands, grant, result handshake.
// The err signal exists only when ALU4_ARB_ERR_EN is defined.
interface alu_4_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
);
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] a_in;
    logic [4*NREQ-1:0] b_in;
    logic [4*NREQ-1:0] ctrl_in;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        res_data;
    logic [ID_W-1:0]   res_id;
`ifdef ALU4_ARB_ERR_EN
    logic              err;

    modport master (
        output req, a_in, b_in, ctrl_in, res_ready,
        input  gnt, busy, res_valid, res_data, res_id, err
    );

    modport slave (
        input  req, a_in, b_in, ctrl_in, res_ready,
        output gnt, busy, res_valid, res_data, res_id, err
    );
`else
    modport master (
        output req, a_in, b_in, ctrl_in, res_ready,
        input  gnt, busy, res_valid, res_data, res_id
    );

    modport slave (
        input  req, a_in, b_in, ctrl_in, res_ready,
        output gnt, busy, res_valid, res_data, res_id
    );
`endif
endinterface

// File: rtl/alu_4_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU among NREQ requesters; IDLE -> EXEC -> RESP per op.
// Define ALU4_ARB_ERR_EN to add the registered illegal-opcode err output.
module alu_4_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input logic            clk,
    input logic            rst,
    alu_4_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpNot  = 4'd4;
    localparam logic [3:0] OpNand = 4'd5;
    localparam logic [3:0] OpNor  = 4'd6;
    localparam logic [3:0] OpXor  = 4'd7;
    localparam logic [3:0] OpXnor = 4'd8;
    localparam logic [3:0] OpMul  = 4'd9;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [3:0]      op_a_q, op_a_d;
    logic [3:0]      op_b_q, op_b_d;
    logic [3:0]      op_ctrl_q, op_ctrl_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
`ifdef ALU4_ARB_ERR_EN
    logic            err_q, err_d;
`endif

    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] scan_id;
    logic [3:0]      pick_a, pick_b, pick_ctrl;
    logic [7:0]      alu_y;
    logic            alu_illegal;

    // Circular scan starting at rr_ptr; the first requesting index wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        pick_a     = 4'h0;
        pick_b     = 4'h0;
        pick_ctrl  = 4'h0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (32'(rr_ptr_q) + k >= NREQ) begin
                scan_id = rr_ptr_q + ID_W'(k) - ID_W'(NREQ);
            end else begin
                scan_id = rr_ptr_q + ID_W'(k);
            end
            if (!pick_found && bus.req[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick_id == ID_W'(k)) begin
                pick_a    = bus.a_in[4*k +: 4];
                pick_b    = bus.b_in[4*k +: 4];
                pick_ctrl = bus.ctrl_in[4*k +: 4];
            end
        end
    end

    // Shared ALU datapath, fed only from the latched operands.
    always_comb begin
        alu_y       = 8'h00;
        alu_illegal = 1'b0;
        case (op_ctrl_q)
            OpAdd:   alu_y = {3'b000, {1'b0, op_a_q} + {1'b0, op_b_q}};
            OpSub:   alu_y = {3'b000, {1'b0, op_a_q} + {1'b0, ~op_b_q} + 5'd1};
            OpAnd:   alu_y = {4'h0, op_a_q & op_b_q};
            OpOr:    alu_y = {4'h0, op_a_q | op_b_q};
            OpNot:   alu_y = {4'h0, ~op_a_q};
            OpNand:  alu_y = {4'h0, ~(op_a_q & op_b_q)};
            OpNor:   alu_y = {4'h0, ~(op_a_q | op_b_q)};
            OpXor:   alu_y = {4'h0, op_a_q ^ op_b_q};
            OpXnor:  alu_y = {4'h0, ~(op_a_q ^ op_b_q)};
            OpMul:   alu_y = {4'h0, op_a_q} * {4'h0, op_b_q};
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_ctrl_d   = op_ctrl_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
`ifdef ALU4_ARB_ERR_EN
        err_d       = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d[pick_id] = 1'b1;
                    op_a_d         = pick_a;
                    op_b_d         = pick_b;
                    op_ctrl_d      = pick_ctrl;
                    id_d           = pick_id;
                    state_d        = StExec;
                end
            end
            StExec: begin
                res_data_d  = alu_y;
                res_valid_d = 1'b1;
`ifdef ALU4_ARB_ERR_EN
                err_d       = alu_illegal;
`endif
                state_d     = StResp;
            end
            StResp: begin
                // res_ready is only looked at here, so an early ready has no effect.
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
`ifdef ALU4_ARB_ERR_EN
                    err_d       = 1'b0;
`endif
                    rr_ptr_d    = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            op_a_q      <= 4'h0;
            op_b_q      <= 4'h0;
            op_ctrl_q   <= 4'h0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
`ifdef ALU4_ARB_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_ctrl_q   <= op_ctrl_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
`ifdef ALU4_ARB_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = id_q;
`ifdef ALU4_ARB_ERR_EN
    assign bus.err       = err_q;
`endif

`ifndef SYNTHESIS
    gnt_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    res_hold_a: assert property (@(posedge clk) disable iff (rst)
        res_valid_q && !bus.res_ready |=> res_valid_q && $stable(res_data_q) && $stable(id_q));
`endif

endmodule

// File: tb/tb_alu_4_arbiter.sv
// Self-checking bench for alu_4_arbiter: directed vector table, randomized ops against a
// reference model, plus backpressure and mid-operation reset sequences.
module tb_alu_4_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned ID_W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_4_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

    alu_4_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rr_ptr   = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        int          stall;
        int          id;
        int          data;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nib(input logic [15:0] v, input int i);
        return int'((v >> (4 * i)) & 16'h000F);
    endfunction

    // Operation results from plain integer arithmetic on 0..15 operands.
    function automatic int ref_alu(input int a, input int b, input int op);
        case (op)
            0:       return a + b;
            1:       return (a - b + 16) % 32;
            2:       return a & b;
            3:       return a | b;
            4:       return 15 - a;
            5:       return 15 - (a & b);
            6:       return 15 - (a | b);
            7:       return a ^ b;
            8:       return 15 - (a ^ b);
            9:       return a * b;
            default: return 0;
        endcase
    endfunction

    function automatic int pick(input logic [3:0] req_v, input int ptr);
        for (int k = 0; k < int'(NREQ); k++) begin
            int i;
            i = (ptr + k) % int'(NREQ);
            if (req_v[i]) return i;
        end
        return -1;
    endfunction

    // Called on a negedge; returns on the negedge after the handshake.
    task automatic txn(input logic [3:0] req_v, input logic [15:0] a_v, input logic [15:0] b_v,
                       input logic [15:0] c_v, input int stall, input int exp_id,
                       input int exp_data, input string tag);
        int exp_err;
        exp_err       = (nib(c_v, exp_id) >= 10) ? 1 : 0;
        bus.req       = req_v;
        bus.a_in      = a_v;
        bus.b_in      = b_v;
        bus.ctrl_in   = c_v;
        bus.res_ready = (stall == 0);
        @(negedge clk);
        check($sformatf("%s gnt", tag), 32'(bus.gnt), 32'(1 << exp_id));
        check($sformatf("%s busy@gnt", tag), 32'(bus.busy), 32'd1);
        check($sformatf("%s valid@gnt", tag), 32'(bus.res_valid), 32'd0);
        bus.req[exp_id] = 1'b0;
        @(negedge clk);
        check($sformatf("%s valid", tag), 32'(bus.res_valid), 32'd1);
        check($sformatf("%s data", tag), 32'(bus.res_data), 32'(exp_data));
        check($sformatf("%s id", tag), 32'(bus.res_id), 32'(exp_id));
        check($sformatf("%s gnt@resp", tag), 32'(bus.gnt), 32'd0);
`ifdef ALU4_ARB_ERR_EN
        check($sformatf("%s err", tag), 32'(bus.err), 32'(exp_err));
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check($sformatf("%s stall valid", tag), 32'(bus.res_valid), 32'd1);
            check($sformatf("%s stall data", tag), 32'(bus.res_data), 32'(exp_data));
            check($sformatf("%s stall id", tag), 32'(bus.res_id), 32'(exp_id));
            check($sformatf("%s stall gnt", tag), 32'(bus.gnt), 32'd0);
            check($sformatf("%s stall busy", tag), 32'(bus.busy), 32'd1);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check($sformatf("%s valid@done", tag), 32'(bus.res_valid), 32'd0);
        check($sformatf("%s busy@done", tag), 32'(bus.busy), 32'd0);
`ifdef ALU4_ARB_ERR_EN
        check($sformatf("%s err@done", tag), 32'(bus.err), 32'd0);
`endif
        rr_ptr = (exp_id + 1) % int'(NREQ);
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 16'h0005, 16'h0003, 16'h0000, 0, 0, 8'h08};
        vecs[1]  = '{4'b0100, 16'h0300, 16'h0500, 16'h0100, 0, 2, 8'h0E};
        vecs[2]  = '{4'b0100, 16'h0500, 16'h0300, 16'h0100, 5, 2, 8'h12};
        vecs[3]  = '{4'b1000, 16'hC000, 16'hA000, 16'h2000, 0, 3, 8'h08};
        vecs[4]  = '{4'b1111, 16'h4321, 16'hFFFF, 16'h9999, 0, 0, 8'h0F};
        vecs[5]  = '{4'b1111, 16'h4321, 16'hFFFF, 16'h9999, 0, 1, 8'h1E};
        vecs[6]  = '{4'b1111, 16'h4321, 16'hFFFF, 16'h9999, 0, 2, 8'h2D};
        vecs[7]  = '{4'b1111, 16'h4321, 16'hFFFF, 16'h9999, 0, 3, 8'h3C};
        vecs[8]  = '{4'b0010, 16'h0070, 16'h0090, 16'h00C0, 0, 1, 8'h00};
        vecs[9]  = '{4'b1001, 16'hF00F, 16'hF001, 16'h9000, 1, 3, 8'hE1};
        vecs[10] = '{4'b1001, 16'hF00F, 16'hF001, 16'h9000, 0, 0, 8'h10};
        vecs[11] = '{4'b0010, 16'h0050, 16'h0000, 16'h0040, 0, 1, 8'h0A};
        vecs[12] = '{4'b0100, 16'h0C00, 16'h0A00, 16'h0700, 0, 2, 8'h06};
        vecs[13] = '{4'b0001, 16'h000C, 16'h000A, 16'h0005, 0, 0, 8'h07};
        vecs[14] = '{4'b0010, 16'h00C0, 16'h00A0, 16'h0060, 0, 1, 8'h01};
        vecs[15] = '{4'b0100, 16'h0C00, 16'h0A00, 16'h0800, 0, 2, 8'h09};
        vecs[16] = '{4'b1000, 16'hC000, 16'hA000, 16'h3000, 0, 3, 8'h0E};

        rst           = 1'b1;
        bus.req       = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.ctrl_in   = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset gnt", 32'(bus.gnt), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset valid", 32'(bus.res_valid), 32'd0);
        check("reset data", 32'(bus.res_data), 32'd0);
        check("reset id", 32'(bus.res_id), 32'd0);
`ifdef ALU4_ARB_ERR_EN
        check("reset err", 32'(bus.err), 32'd0);
`endif
        rst = 1'b0;

        foreach (vecs[i]) begin
            txn(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].stall, vecs[i].id,
                vecs[i].data, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  rq;
            logic [15:0] ra, rb, rc;
            int          id;
            rq = 4'($urandom_range(1, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 16'($urandom);
            id = pick(rq, rr_ptr);
            txn(rq, ra, rb, rc, int'($urandom_range(0, 2)), id,
                ref_alu(nib(ra, id), nib(rb, id), nib(rc, id)), $sformatf("rnd%0d", n));
        end

        // New request during EXEC must wait; dropping it before grant means it is never served.
        begin
            int x, y;
            x = rr_ptr;
            y = (x + 2) % int'(NREQ);
            bus.req       = 4'(1 << x);
            bus.a_in      = 16'h2222;
            bus.b_in      = 16'h3333;
            bus.ctrl_in   = 16'h0000;
            bus.res_ready = 1'b0;
            @(negedge clk);
            check("busy gnt", 32'(bus.gnt), 32'(1 << x));
            bus.req = 4'(1 << y);
            @(negedge clk);
            check("busy gnt@resp", 32'(bus.gnt), 32'd0);
            check("busy data", 32'(bus.res_data), 32'h05);
            check("busy id", 32'(bus.res_id), 32'(x));
            @(negedge clk);
            check("busy gnt@stall", 32'(bus.gnt), 32'd0);
            check("busy busy@stall", 32'(bus.busy), 32'd1);
            check("busy valid@stall", 32'(bus.res_valid), 32'd1);
            bus.req       = '0;
            bus.res_ready = 1'b1;
            @(negedge clk);
            check("busy valid@done", 32'(bus.res_valid), 32'd0);
            check("busy idle", 32'(bus.busy), 32'd0);
            @(negedge clk);
            check("dropped req no gnt", 32'(bus.gnt), 32'd0);
            check("dropped req idle", 32'(bus.busy), 32'd0);
            rr_ptr = (x + 1) % int'(NREQ);
        end

        // Reset during EXEC aborts the op; the still-held request is granted anew afterwards.
        begin
            int z;
            z = (rr_ptr + 1) % int'(NREQ);
            bus.req       = 4'(1 << z);
            bus.a_in      = 16'h4444;
            bus.b_in      = 16'h4444;
            bus.ctrl_in   = 16'h9999;
            bus.res_ready = 1'b1;
            @(negedge clk);
            check("rst gnt", 32'(bus.gnt), 32'(1 << z));
            rst = 1'b1;
            @(negedge clk);
            check("rst valid", 32'(bus.res_valid), 32'd0);
            check("rst busy", 32'(bus.busy), 32'd0);
            check("rst gnt0", 32'(bus.gnt), 32'd0);
            check("rst data", 32'(bus.res_data), 32'd0);
            check("rst id", 32'(bus.res_id), 32'd0);
            @(negedge clk);
            check("rst no regrant", 32'(bus.gnt), 32'd0);
            check("rst valid2", 32'(bus.res_valid), 32'd0);
            rst = 1'b0;
            @(negedge clk);
            check("rst fresh gnt", 32'(bus.gnt), 32'(1 << z));
            bus.req = '0;
            @(negedge clk);
            check("rst fresh valid", 32'(bus.res_valid), 32'd1);
            check("rst fresh data", 32'(bus.res_data), 32'h10);
            check("rst fresh id", 32'(bus.res_id), 32'(z));
            @(negedge clk);
            check("rst fresh done", 32'(bus.res_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
